// File: rtl/ld_bus_sequencer.sv
// Sequences the shared LD bus through its MSB, LSB and data transceiver windows once per
// Apple II bus cycle, latching the 16-bit bus address along the way.
module ld_bus_sequencer #(
   parameter int unsigned MSB_CLKS  = 1,
   parameter int unsigned LSB_CLKS  = 1,
   parameter int unsigned TURN_CLKS = 1
) (
   input  logic        M7Hz,
   input  logic        nSYSRESET,
   input  logic        PHI0,
   input  logic        nWR,
   input  logic        nLSEL,
   input  logic [7:0]  LD,
   input  logic        LATECLR,
   output logic        nMSBOE,
   output logic        nLSBOE,
   output logic        nDATAOE,
   output logic        nDATADIR,
   output logic [15:0] BUSADDR,
   output logic        ADDRVALID,
   output logic        ADDRLATE
);

   typedef enum logic [2:0] {
      StSync,
      StTurn,
      StMsb,
      StLsb,
      StWait,
      StData
   } state_e;

   localparam logic [1:0] TurnLast = 2'(TURN_CLKS - 1);
   localparam logic [1:0] MsbLast  = 2'(MSB_CLKS - 1);
   localparam logic [1:0] LsbLast  = 2'(LSB_CLKS - 1);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        early_q, early_d;
   logic        phi_q;
   logic        msb_oe_n_q, msb_oe_n_d;
   logic        lsb_oe_n_q, lsb_oe_n_d;
   logic        data_oe_n_q, data_oe_n_d;
   logic        data_dir_n_q, data_dir_n_d;
   logic [15:0] busaddr_q, busaddr_d;
   logic        addrvalid_q, addrvalid_d;
   logic        addrlate_q, addrlate_d;

   logic        fall;
   logic        rise;
   logic        start_cycle;
   logic        dir_n_sel;

   // PHI0 is phase-locked to M7Hz, so one register is enough for edge detection.
   assign fall = phi_q & ~PHI0;
   assign rise = ~phi_q & PHI0;

   // Card drives the Apple bus only for a selected read in the $Cxxx space.
   assign dir_n_sel = ~(nWR & ~nLSEL & (busaddr_q[15:12] == 4'hC));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      early_d      = early_q;
      msb_oe_n_d   = msb_oe_n_q;
      lsb_oe_n_d   = lsb_oe_n_q;
      data_oe_n_d  = data_oe_n_q;
      data_dir_n_d = data_dir_n_q;
      busaddr_d    = busaddr_q;
      addrvalid_d  = 1'b0;
      addrlate_d   = addrlate_q;
      start_cycle  = 1'b0;

      case (state_q)
         StSync: begin
            if (fall) begin
               start_cycle = 1'b1;
            end
         end
         StTurn: begin
            if (cnt_q == TurnLast) begin
               state_d    = StMsb;
               cnt_d      = 2'd0;
               msb_oe_n_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StMsb: begin
            if (rise) begin
               early_d    = 1'b1;
               addrlate_d = 1'b1;
            end
            if (cnt_q == MsbLast) begin
               busaddr_d[15:8] = LD;
               msb_oe_n_d      = 1'b1;
               lsb_oe_n_d      = 1'b0;
               state_d         = StLsb;
               cnt_d           = 2'd0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StLsb: begin
            if (cnt_q == LsbLast) begin
               // A rise on the capture edge itself is on time: the address completes here.
               busaddr_d[7:0] = LD;
               lsb_oe_n_d     = 1'b1;
               addrvalid_d    = 1'b1;
               cnt_d          = 2'd0;
               if (early_q || rise) begin
                  state_d      = StData;
                  data_oe_n_d  = 1'b0;
                  data_dir_n_d = dir_n_sel;
               end else begin
                  state_d = StWait;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
               if (rise) begin
                  early_d    = 1'b1;
                  addrlate_d = 1'b1;
               end
            end
         end
         StWait: begin
            if (rise) begin
               state_d      = StData;
               data_oe_n_d  = 1'b0;
               data_dir_n_d = dir_n_sel;
            end
         end
         StData: begin
            if (fall) begin
               data_oe_n_d  = 1'b1;
               data_dir_n_d = 1'b1;
               start_cycle  = 1'b1;
            end
         end
         default: begin
            state_d = StSync;
         end
      endcase

      if (start_cycle) begin
         cnt_d   = 2'd0;
         early_d = 1'b0;
         if (TURN_CLKS == 0) begin
            state_d    = StMsb;
            msb_oe_n_d = 1'b0;
         end else begin
            state_d = StTurn;
         end
      end

      if (LATECLR) begin
         addrlate_d = 1'b0;
      end
   end

   always_ff @(posedge M7Hz) begin
      phi_q <= PHI0;
      if (!nSYSRESET) begin
         state_q      <= StSync;
         cnt_q        <= 2'd0;
         early_q      <= 1'b0;
         msb_oe_n_q   <= 1'b1;
         lsb_oe_n_q   <= 1'b1;
         data_oe_n_q  <= 1'b1;
         data_dir_n_q <= 1'b1;
         busaddr_q    <= 16'h0000;
         addrvalid_q  <= 1'b0;
         addrlate_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         early_q      <= early_d;
         msb_oe_n_q   <= msb_oe_n_d;
         lsb_oe_n_q   <= lsb_oe_n_d;
         data_oe_n_q  <= data_oe_n_d;
         data_dir_n_q <= data_dir_n_d;
         busaddr_q    <= busaddr_d;
         addrvalid_q  <= addrvalid_d;
         addrlate_q   <= addrlate_d;
      end
   end

   assign nMSBOE    = msb_oe_n_q;
   assign nLSBOE    = lsb_oe_n_q;
   assign nDATAOE   = data_oe_n_q;
   assign nDATADIR  = data_dir_n_q;
   assign BUSADDR   = busaddr_q;
   assign ADDRVALID = addrvalid_q;
   assign ADDRLATE  = addrlate_q;

endmodule
